cam_cmd_sequencer: RTL and testbench

//  Command front-end sitting directly upstream of the 16x8 CAM.
//  - Buffers write/search commands from the pin decoder in a small FIFO.
//  - Issues them to the CAM one at a time, in order.
//  - Captures the CAM match result and returns it on a valid/ready response port.
//  - Decouples the pin-level command rate from CAM timing and guarantees write-before-search ordering.

---
 rtl/cam_cmd_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_cam_cmd_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cam_cmd_sequencer
//  Purpose  : Command front-end for a 16x8 CAM. Buffers write/search commands
//             in a small FIFO, issues them to the CAM one at a time in order,
//             captures the match result and returns it on a valid/ready port.
//             A write is always followed by at least one IDLE cycle, so a
//             search queued behind it sees the written data.
//  Ports    : clk, rst             - clock, synchronous active-high reset
//             cmd_valid/cmd_ready  - command handshake (cmd_ready registered)
//             cmd_write/addr/data  - 1=write data@addr, 0=search for data
//             cam_we/waddr/wdata   - one-cycle CAM write strobe and fields
//             cam_search/cam_key   - one-cycle CAM search strobe and key
//             cam_found/match_addr - CAM result, valid CAM_LAT after search
//             rsp_valid/rsp_ready  - response handshake, held until accepted
//             rsp_found/rsp_addr   - captured match (addr 0 when not found)
//             busy                 - FIFO non-empty or FSM not IDLE
//  Options  : CAM_SEQ_WR_ACK_EN - when defined, each write also returns a
//             response (found=1, addr=written address).
//  Revision : 1.0 - initial release
// ============================================================================
module cam_cmd_sequencer #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 4,
    parameter int DATA_W  = 8,
    parameter int CAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              cam_we,
    output logic [ADDR_W-1:0] cam_waddr,
    output logic [DATA_W-1:0] cam_wdata,
    output logic              cam_search,
    output logic [DATA_W-1:0] cam_key,
    input  logic              cam_found,
    input  logic [ADDR_W-1:0] cam_match_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_found,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              busy
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = 1 + ADDR_W + DATA_W;
    localparam int c_LAT_W = (CAM_LAT > 1) ? $clog2(CAM_LAT) : 1;

    localparam logic [c_CNT_W-1:0] c_DEPTH    = c_CNT_W'(DEPTH);
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(CAM_LAT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [c_ENT_W-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_CNT_W-1:0] r_count;
    logic               r_cmd_ready;

    logic [1:0]         r_state;
    logic [c_LAT_W-1:0] r_lat_cnt;

    logic               w_push;
    logic               w_pop;
    logic [c_CNT_W-1:0] w_count_nxt;
    logic [c_ENT_W-1:0] w_head;
    logic               w_head_write;
    logic [ADDR_W-1:0]  w_head_addr;
    logic [DATA_W-1:0]  w_head_data;

    assign w_push      = cmd_valid & r_cmd_ready;
    assign w_pop       = (r_state == c_S_IDLE) && (r_count != '0);
    assign w_count_nxt = r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);

    assign w_head       = r_mem[r_rptr];
    assign w_head_write = w_head[c_ENT_W-1];
    assign w_head_addr  = w_head[DATA_W +: ADDR_W];
    assign w_head_data  = w_head[DATA_W-1:0];

    assign cmd_ready = r_cmd_ready;
    assign busy      = (r_count != '0) || (r_state != c_S_IDLE);

    // Storage needs no reset: occupancy is tracked by the pointers/count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {cmd_write, cmd_addr, cmd_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            // Registered full flag: a same-cycle pop does not reopen the port.
            r_cmd_ready <= (w_count_nxt != c_DEPTH);
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue / response FSM. Strobes are registered on the IDLE->ISSUE
    // transition so they are high exactly during the ISSUE cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_lat_cnt  <= '0;
            cam_we     <= 1'b0;
            cam_waddr  <= '0;
            cam_wdata  <= '0;
            cam_search <= 1'b0;
            cam_key    <= '0;
            rsp_valid  <= 1'b0;
            rsp_found  <= 1'b0;
            rsp_addr   <= '0;
        end else begin
            cam_we     <= 1'b0;
            cam_search <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        if (w_head_write) begin
                            cam_we    <= 1'b1;
                            cam_waddr <= w_head_addr;
                            cam_wdata <= w_head_data;
                        end else begin
                            cam_search <= 1'b1;
                            cam_key    <= w_head_data;
                        end
                        r_state <= c_S_ISSUE;
                    end
                end
                c_S_ISSUE: begin
                    // cam_we/cam_waddr still reflect the command being issued.
                    if (cam_we) begin
`ifdef CAM_SEQ_WR_ACK_EN
                        rsp_valid <= 1'b1;
                        rsp_found <= 1'b1;
                        rsp_addr  <= cam_waddr;
                        r_state   <= c_S_RESP;
`else
                        r_state   <= c_S_IDLE;
`endif
                    end else begin
                        r_lat_cnt <= '0;
                        r_state   <= c_S_WAIT;
                    end
                end
                c_S_WAIT: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_found <= cam_found;
                        rsp_addr  <= cam_found ? cam_match_addr : '0;
                        r_state   <= c_S_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                c_S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= c_S_IDLE;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_cmd_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cam_cmd_sequencer
//  Purpose  : Self-checking bench for cam_cmd_sequencer. A small CAM model
//             answers the DUT strobes; a reference model predicts the
//             response stream in command-accept order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cam_cmd_sequencer;

    localparam int DEPTH   = 4;
    localparam int ADDR_W  = 4;
    localparam int DATA_W  = 8;
    localparam int CAM_LAT = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_write = 1'b0;
    logic [ADDR_W-1:0] cmd_addr = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              cam_we;
    logic [ADDR_W-1:0] cam_waddr;
    logic [DATA_W-1:0] cam_wdata;
    logic              cam_search;
    logic [DATA_W-1:0] cam_key;
    logic              cam_found = 1'b0;
    logic [ADDR_W-1:0] cam_match_addr = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic              rsp_found;
    logic [ADDR_W-1:0] rsp_addr;
    logic              busy;

    int checks    = 0;
    int failures  = 0;
    int rsp_count = 0;
    int exp_total = 0;

    always #5 clk = ~clk;

    cam_cmd_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .CAM_LAT(CAM_LAT)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_addr      (cmd_addr),
        .cmd_data      (cmd_data),
        .cam_we        (cam_we),
        .cam_waddr     (cam_waddr),
        .cam_wdata     (cam_wdata),
        .cam_search    (cam_search),
        .cam_key       (cam_key),
        .cam_found     (cam_found),
        .cam_match_addr(cam_match_addr),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_found     (rsp_found),
        .rsp_addr      (rsp_addr),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- CAM model (latency 1, lowest index wins) ----------------
    logic [DATA_W-1:0] cam_mem [16] = '{default: 8'h00};

    function automatic logic [4:0] cam_pick(input logic [7:0] key, input logic [3:0] junk);
        logic [4:0] r;
        r = {1'b0, junk};   // address is garbage on a miss
        for (int i = 15; i >= 0; i--) begin
            if (cam_mem[i] == key) r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (cam_we) cam_mem[cam_waddr] <= cam_wdata;
        if (cam_search) {cam_found, cam_match_addr} <= cam_pick(cam_key, 4'($urandom));
    end

    // ---------------- Reference model ----------------
    logic [DATA_W-1:0] ref_mem [16] = '{default: 8'h00};
    logic [4:0]        exp_q[$];

    task automatic model_accept(input logic wr, input logic [3:0] a, input logic [7:0] d);
        logic       f;
        logic [3:0] fa;
        if (wr) begin
            ref_mem[a] = d;
`ifdef CAM_SEQ_WR_ACK_EN
            exp_q.push_back({1'b1, a});
            exp_total++;
`endif
        end else begin
            f  = 1'b0;
            fa = 4'h0;
            for (int i = 0; i < 16; i++) begin
                if (!f && ref_mem[i] == d) begin
                    f  = 1'b1;
                    fa = 4'(i);
                end
            end
            exp_q.push_back({f, fa});
            exp_total++;
        end
    endtask

    // ---------------- Response monitor ----------------
    logic       hold_p = 1'b0;
    logic       hold_f = 1'b0;
    logic [3:0] hold_a = 4'h0;

    always @(negedge clk) begin
        if (rst) begin
            hold_p <= 1'b0;
        end else begin
            if (hold_p) begin
                check("rsp_hold_valid", 32'(rsp_valid), 32'(1));
                check("rsp_hold_data", 32'({rsp_found, rsp_addr}), 32'({hold_f, hold_a}));
            end
            if (cam_we === 1'b1 || cam_search === 1'b1)
                check("strobe_excl", 32'(cam_we & cam_search), 32'(0));
            if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("rsp_extra", 32'(exp_q.size()), 32'(1));
                end else begin
                    check("rsp_data", 32'({rsp_found, rsp_addr}), 32'(exp_q.pop_front()));
                end
                rsp_count++;
            end
            hold_p <= (rsp_valid === 1'b1) && (rsp_ready !== 1'b1);
            hold_f <= rsp_found;
            hold_a <= rsp_addr;
        end
    end

    // ---------------- Stimulus helpers (all return at posedge+1) ----------------
    task automatic push(input logic wr, input logic [3:0] a, input logic [7:0] d, input bit rnd_ready);
        bit ok;
        int n;
        ok        = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_data  = d;
        for (n = 0; n < 300; n++) begin
            ok = cmd_ready;
            if (rnd_ready) rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (ok) model_accept(wr, a, d);
        else check("push_timeout", 32'(n), 32'(0));
        cmd_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        for (int n = 0; n < 2000; n++) begin
            if (exp_q.size() == 0 && !busy && !rsp_valid) break;
            rsp_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            @(posedge clk);
            #1;
        end
        check("drain_left", 32'(exp_q.size()), 32'(0));
        check("drain_busy", 32'(busy), 32'(0));
    endtask

    // ---------------- Directed + random sequence ----------------
    initial begin
        int n;
        int quiet;
        logic [7:0] k;

        // Reset for two cycles, then check every output.
        rst       = 1'b1;
        rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_cam_we", 32'(cam_we), 32'(0));
        check("rst_cam_search", 32'(cam_search), 32'(0));
        check("rst_cam_waddr", 32'(cam_waddr), 32'(0));
        check("rst_cam_wdata", 32'(cam_wdata), 32'(0));
        check("rst_cam_key", 32'(cam_key), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_found", 32'(rsp_found), 32'(0));
        check("rst_rsp_addr", 32'(rsp_addr), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        rst = 1'b0;

        // Four writes then four searches.
        rsp_ready = 1'b1;
        push(1'b1, 4'd0,  8'h55, 1'b0);
        push(1'b1, 4'd1,  8'hAA, 1'b0);
        push(1'b1, 4'd2,  8'h77, 1'b0);
        push(1'b1, 4'd15, 8'h33, 1'b0);
        push(1'b0, 4'd0,  8'h55, 1'b0);
        push(1'b0, 4'd0,  8'hAA, 1'b0);
        push(1'b0, 4'd0,  8'h77, 1'b0);
        push(1'b0, 4'd0,  8'h33, 1'b0);
        drain(1'b0);

        // Miss and lowest-index multi-match.
        push(1'b0, 4'd0, 8'hFF, 1'b0);
        push(1'b0, 4'd0, 8'h00, 1'b0);
        drain(1'b0);

        // Latency of a lone search into an idle block.
        rsp_ready = 1'b0;
        push(1'b0, 4'd0, 8'h55, 1'b0);
        for (n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) break;
        end
        check("search_latency", 32'(n), 32'(2 + CAM_LAT));
        drain(1'b0);

        // Stalled consumer: DEPTH+1 back-to-back accepts, then port closes.
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(1'b0, 4'd0, 8'(8'h11 * $urandom_range(0, 5)), 1'b0);
        check("full_cmd_ready", 32'(cmd_ready), 32'(0));
        repeat (3) @(posedge clk);
        #1;
        check("full_cmd_ready_held", 32'(cmd_ready), 32'(0));
        check("full_rsp_valid", 32'(rsp_valid), 32'(1));
        drain(1'b0);

        // Write then immediate searches of old and new value.
        rsp_ready = 1'b1;
        push(1'b1, 4'd1, 8'hCC, 1'b0);
        push(1'b0, 4'd0, 8'hAA, 1'b0);
        push(1'b0, 4'd0, 8'hCC, 1'b0);
        drain(1'b0);

        // Reset while a search waits for the CAM with three commands queued.
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) push(1'b0, 4'd0, 8'(8'h11 * $urandom_range(0, 5)), 1'b0);
        rsp_ready = 1'b1;  // release the first response only
        for (n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (cam_search) break;
        end
        check("pre_rst_search", 32'(cam_search), 32'(1));
        @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_total -= exp_q.size();
        exp_q.delete();
        check("post_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("post_rst_busy", 32'(busy), 32'(0));
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'(1));
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            if (cam_we || cam_search || rsp_valid || busy) quiet++;
            @(posedge clk);
            #1;
        end
        check("post_rst_quiet", 32'(quiet), 32'(0));

        // Random mix with a randomly stalling consumer.
        for (int i = 0; i < 80; i++) begin
            k = 8'(8'h11 * $urandom_range(0, 3));
            push(($urandom_range(0, 2) == 0), 4'($urandom), k, 1'b1);
        end
        drain(1'b1);

        check("rsp_total", 32'(rsp_count), 32'(exp_total));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
